ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/wait_counter.sv | 29 ++
 rtl/ram_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizing for the CPU/debug RAM arbiter.
`timescale 1ns/1ps
package ram_arbiter_pkg;
  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 4;
  localparam int WAIT_LIMIT_DEF = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FORCE = 2'b01,
    DBG   = 2'b10,
    ACK   = 2'b11
  } arb_state_t;
endpackage

// File: rtl/wait_counter.sv
// Saturating count of CPU-busy cycles seen while a debug request waits.
// Holds at LIMIT instead of wrapping so the force decision can never be missed.
`timescale 1ns/1ps
module wait_counter
  import ram_arbiter_pkg::*;
#(
  parameter int LIMIT = WAIT_LIMIT_DEF,
  parameter int W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_saturated
);
  logic [W-1:0] r_count;

  assign o_saturated = (r_count == W'(LIMIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_saturated) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the CPU and a debug/loader port; the CPU has priority
// until it has kept a debug request waiting WAIT_LIMIT cycles, then it is held.
`timescale 1ns/1ps
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              w_inc;
  logic              w_clr;
  logic              w_sat;
  logic [DATA_W-1:0] r_dbg_rdata;

  wait_counter #(
    .LIMIT (WAIT_LIMIT),
    .W     (CNT_W)
  ) u_wait_counter (
    .clock       (clock),
    .reset       (reset),
    .i_inc       (w_inc),
    .i_clr       (w_clr),
    .o_saturated (w_sat)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read data is taken at the edge that leaves DBG; writes leave the last read intact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dbg_rdata <= '0;
    end else if (r_state == DBG && !dbg_we) begin
      r_dbg_rdata <= ram_rdata;
    end
  end

  assign dbg_rdata = r_dbg_rdata;

  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!dbg_req) begin
          w_clr = 1'b1;
        end else if (!cpu_cs) begin
          w_next = DBG;
        end else begin
          w_inc = 1'b1;
          if (w_sat) begin
            w_next = FORCE;
          end
        end
      end
      FORCE:   w_next = dbg_req ? DBG : IDLE;
      DBG:     w_next = ACK;
      ACK: begin
        w_clr  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FORCE parks the RAM for one cycle so the held CPU's in-flight access is dropped cleanly.
  always_comb begin
    ram_cs    = cpu_cs;
    ram_we    = cpu_we;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    cpu_rdata = ram_rdata;
    cpu_hold  = 1'b0;
    dbg_ack   = 1'b0;
    case (r_state)
      FORCE: begin
        cpu_hold  = 1'b1;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        cpu_rdata = '0;
      end
      DBG: begin
        cpu_hold  = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = dbg_we;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
        cpu_rdata = '0;
      end
      ACK:     dbg_ack = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, corner-case sequences, then random traffic
// checked against a cycle-level behavioural model with its own copy of the RAM.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 4;
  localparam int WL = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_hold;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Asynchronous-read, synchronous-write RAM behind the arbiter.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clock) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cs, input logic we, input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                       input logic rq, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dw);
    @(negedge clock);
    cpu_cs = cs; cpu_we = we; cpu_addr = ca; cpu_wdata = cw;
    dbg_req = rq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dw;
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock);
    #1 pl_en = 1'b0;
  endtask

  typedef struct {
    logic          cs;
    logic [AW-1:0] ca;
    logic          rq;
    logic          dwe;
    logic [AW-1:0] da;
    logic [DW-1:0] dw;
    logic          e_hold;
    logic          e_ack;
    logic          e_rcs;
    logic          e_rwe;
    logic          achk;
    logic [AW-1:0] e_raddr;
    logic [DW-1:0] e_drd;
  } vec_t;

  function automatic vec_t mk(logic cs, logic [AW-1:0] ca, logic rq, logic dwe, logic [AW-1:0] da,
                              logic [DW-1:0] dw, logic eh, logic ea, logic ecs, logic ewe,
                              logic achk, logic [AW-1:0] eaddr, logic [DW-1:0] edrd);
    vec_t v;
    v.cs = cs; v.ca = ca; v.rq = rq; v.dwe = dwe; v.da = da; v.dw = dw;
    v.e_hold = eh; v.e_ack = ea; v.e_rcs = ecs; v.e_rwe = ewe;
    v.achk = achk; v.e_raddr = eaddr; v.e_drd = edrd;
    return v;
  endfunction

  vec_t          tbl [16];
  int            acks [$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            m_force, m_serve, m_ack, n_force, n_serve, n_ack, owned;
  int            m_busy, hold_run, req_since, pct;
  bit            req_intact;
  logic [DW-1:0] m_drd;

  initial begin
    // Idle grant write, then a starved read of the same location.
    tbl[0] = mk(0, 12'h111, 1, 1, 12'h0A5, 4'h9, 0, 0, 0, 0, 1, 12'h111, 4'h0);
    tbl[1] = mk(0, 12'h111, 1, 1, 12'h0A5, 4'h9, 1, 0, 1, 1, 1, 12'h0A5, 4'h0);
    tbl[2] = mk(0, 12'h111, 0, 1, 12'h0A5, 4'h9, 0, 1, 0, 0, 1, 12'h111, 4'h0);
    tbl[3] = mk(0, 12'h111, 0, 0, 12'h000, 4'h0, 0, 0, 0, 0, 1, 12'h111, 4'h0);
    for (int k = 0; k < 8; k++)
      tbl[4+k] = mk(1, 12'h222, 1, 0, 12'h0A5, 4'h0, 0, 0, 1, 0, 1, 12'h222, 4'h0);
    tbl[12] = mk(1, 12'h222, 1, 0, 12'h0A5, 4'h0, 1, 0, 0, 0, 0, 12'h000, 4'h0);
    tbl[13] = mk(1, 12'h222, 1, 0, 12'h0A5, 4'h0, 1, 0, 1, 0, 1, 12'h0A5, 4'h0);
    tbl[14] = mk(1, 12'h222, 0, 0, 12'h0A5, 4'h0, 0, 1, 1, 0, 1, 12'h222, 4'h9);
    tbl[15] = mk(0, 12'h222, 0, 0, 12'h0A5, 4'h0, 0, 0, 0, 0, 1, 12'h222, 4'h9);

    // Reset held with a pending debug request.
    drive(0, 0, 12'h321, 4'h0, 1, 1, 12'h0A5, 4'h9);
    repeat (2) @(posedge clock);
    #1;
    chk("rst hold", 32'(cpu_hold), 32'd0);
    chk("rst ack", 32'(dbg_ack), 32'd0);
    chk("rst dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'h321);
    drive(0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].cs, 0, tbl[i].ca, 4'h0, tbl[i].rq, tbl[i].dwe, tbl[i].da, tbl[i].dw);
      chk($sformatf("vec%0d hold", i), 32'(cpu_hold), 32'(tbl[i].e_hold));
      chk($sformatf("vec%0d ack", i), 32'(dbg_ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d ram_cs", i), 32'(ram_cs), 32'(tbl[i].e_rcs));
      chk($sformatf("vec%0d dbg_rdata", i), 32'(dbg_rdata), 32'(tbl[i].e_drd));
      if (tbl[i].achk) begin
        chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(tbl[i].e_rwe));
        chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_raddr));
      end
    end

    // Debug read of a preloaded word, CPU path restored in the ack cycle.
    preload(12'h3F0, 4'h6);
    preload(12'h010, 4'hC);
    drive(0, 0, 12'h010, 4'h0, 1, 0, 12'h3F0, 4'h0);
    chk("rd idle hold", 32'(cpu_hold), 32'd0);
    drive(0, 0, 12'h010, 4'h0, 1, 0, 12'h3F0, 4'h0);
    chk("rd dbg hold", 32'(cpu_hold), 32'd1);
    chk("rd dbg cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rd dbg ram_addr", 32'(ram_addr), 32'h3F0);
    drive(0, 0, 12'h010, 4'h0, 0, 0, 12'h3F0, 4'h0);
    chk("rd ack", 32'(dbg_ack), 32'd1);
    chk("rd dbg_rdata", 32'(dbg_rdata), 32'h6);
    chk("rd ack ram_addr", 32'(ram_addr), 32'h010);
    chk("rd ack cpu_rdata", 32'(cpu_rdata), 32'hC);

    // Abort while forcing: no access, no ack.
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 12'h044, 4'h0, 1, 1, 12'h055, 4'h7);
      chk($sformatf("abort wait%0d hold", k), 32'(cpu_hold), 32'd0);
    end
    drive(1, 0, 12'h044, 4'h0, 0, 1, 12'h055, 4'h7);
    chk("abort force hold", 32'(cpu_hold), 32'd1);
    chk("abort force ram_cs", 32'(ram_cs), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 12'h044, 4'h0, 0, 1, 12'h055, 4'h7);
      chk($sformatf("abort after%0d hold", k), 32'(cpu_hold), 32'd0);
      chk($sformatf("abort after%0d ack", k), 32'(dbg_ack), 32'd0);
    end

    // Reset landing in DBG.
    drive(0, 0, 12'h066, 4'h0, 1, 0, 12'h3F0, 4'h0);
    drive(0, 0, 12'h066, 4'h0, 1, 0, 12'h3F0, 4'h0);
    chk("rdbg pre hold", 32'(cpu_hold), 32'd1);
    reset = 1'b0;
    #1;
    chk("rdbg hold", 32'(cpu_hold), 32'd0);
    chk("rdbg ack", 32'(dbg_ack), 32'd0);
    chk("rdbg dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rdbg ram_addr", 32'(ram_addr), 32'h066);
    drive(0, 0, 12'h066, 4'h0, 0, 0, 12'h3F0, 4'h0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 12'h066, 4'h0, 0, 0, 12'h3F0, 4'h0);
      chk($sformatf("rdbg post%0d ack", k), 32'(dbg_ack), 32'd0);
    end
    drive(0, 0, 12'h066, 4'h0, 1, 0, 12'h3F0, 4'h0);
    chk("rdbg restart idle", 32'(cpu_hold), 32'd0);
    drive(0, 0, 12'h066, 4'h0, 1, 0, 12'h3F0, 4'h0);
    chk("rdbg restart dbg", 32'(cpu_hold), 32'd1);
    drive(0, 0, 12'h066, 4'h0, 0, 0, 12'h3F0, 4'h0);
    chk("rdbg restart ack", 32'(dbg_ack), 32'd1);
    chk("rdbg restart rdata", 32'(dbg_rdata), 32'h6);

    // Back-to-back: request held across ack, then dropped inside DBG.
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 12'h030, 4'h0, 1, 1, 12'h020, 4'h5);
      if (dbg_ack) begin
        acks.push_back(k);
        chk($sformatf("b2b ack%0d hold", k), 32'(cpu_hold), 32'd0);
        chk($sformatf("b2b ack%0d ram_addr", k), 32'(ram_addr), 32'h030);
      end
    end
    chk("b2b ack count", 32'(acks.size()), 32'd2);
    if (acks.size() == 2) begin
      chk("b2b first ack", 32'(acks[0]), 32'd2);
      chk("b2b gap ge 3", 32'((acks[1] - acks[0]) >= 3), 32'd1);
    end
    drive(0, 0, 12'h030, 4'h0, 0, 1, 12'h020, 4'h5);
    chk("b2b drop in dbg ack", 32'(dbg_ack), 32'd1);
    drive(0, 0, 12'h030, 4'h0, 0, 1, 12'h020, 4'h5);
    chk("b2b idle ack", 32'(dbg_ack), 32'd0);

    // Random traffic against the behavioural model.
    reset = 1'b0;
    drive(0, 0, 12'h000, 4'h0, 0, 0, 12'h000, 4'h0);
    reset = 1'b1;
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = mem[a];
    m_force = 0; m_serve = 0; m_ack = 0; m_busy = 0; m_drd = '0;
    hold_run = 0; req_since = 0; req_intact = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      pct = ((c / 500) % 3 == 0) ? 2 : (((c / 500) % 3 == 1) ? 7 : 10);
      cpu_cs    = ($urandom_range(0, 9) < pct);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 12'($urandom_range(0, 15));
      cpu_wdata = 4'($urandom_range(0, 15));
      if (!dbg_req) begin
        if (!m_ack && $urandom_range(0, 3) == 0) begin
          dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = 12'($urandom_range(0, 15)); dbg_wdata = 4'($urandom_range(0, 15));
          req_since = c; req_intact = 1;
        end
      end else if (m_ack) begin
        if ($urandom_range(0, 3) != 0) dbg_req = 0;
      end else if ($urandom_range(0, 24) == 0) begin
        dbg_req = 0; req_intact = 0;
      end
      #1;
      owned = !m_force && !m_serve;
      chk("rnd hold", 32'(cpu_hold), 32'(m_force || m_serve));
      chk("rnd ack", 32'(dbg_ack), 32'(m_ack));
      chk("rnd ram_cs", 32'(ram_cs), 32'(m_serve ? 1'b1 : (m_force ? 1'b0 : cpu_cs)));
      chk("rnd dbg_rdata", 32'(dbg_rdata), 32'(m_drd));
      if (owned) begin
        chk("rnd cpu ram_addr", 32'(ram_addr), 32'(cpu_addr));
        chk("rnd cpu ram_we", 32'(ram_we), 32'(cpu_we));
        chk("rnd cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[cpu_addr]));
      end else if (m_serve) begin
        chk("rnd dbg ram_addr", 32'(ram_addr), 32'(dbg_addr));
        chk("rnd dbg ram_we", 32'(ram_we), 32'(dbg_we));
        chk("rnd dbg cpu_rdata", 32'(cpu_rdata), 32'd0);
        if (dbg_we) chk("rnd dbg ram_wdata", 32'(ram_wdata), 32'(dbg_wdata));
      end
      hold_run = cpu_hold ? hold_run + 1 : 0;
      chk("rnd hold run le 2", 32'(hold_run <= 2), 32'd1);
      if (dbg_ack && req_intact) chk("rnd ack latency", 32'((c - req_since) <= WL + 3), 32'd1);
      if (dbg_ack && dbg_req) begin req_since = c + 1; req_intact = 1; end

      if (owned && cpu_cs && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (m_serve) begin
        if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        else        m_drd = ref_mem[dbg_addr];
      end
      n_force = 0; n_serve = 0; n_ack = 0;
      if (m_ack) m_busy = 0;
      else if (m_serve) n_ack = 1;
      else if (m_force) n_serve = dbg_req;
      else if (!dbg_req) m_busy = 0;
      else if (!cpu_cs) n_serve = 1;
      else begin
        n_force = (m_busy == WL);
        m_busy  = (m_busy < WL) ? m_busy + 1 : WL;
      end
      m_force = n_force; m_serve = n_serve; m_ack = n_ack;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
